// File: rtl/fsm_intersection_ctrl.sv
// Two-road intersection controller with pedestrian crossing: main road rests green,
// side-road and pedestrian requests are latched and served in alternation.
// Optional night flashing mode is enabled with the FSM_NIGHT_FLASH_EN macro.
module fsm_intersection_ctrl #(
    parameter int CNT_W     = 16,
    parameter int T_MIN_GRN = 1500,
    parameter int T_YLW     = 1500,
    parameter int T_AR      = 500,
    parameter int T_SIDE    = 7500,
    parameter int T_WALK    = 5000,
    parameter int T_FLASH   = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic side_car,
    input  logic ped_btn,
`ifdef FSM_NIGHT_FLASH_EN
    input  logic night,
`endif
    output logic main_grn,
    output logic main_ylw,
    output logic main_red,
    output logic side_grn,
    output logic side_ylw,
    output logic side_red,
    output logic walk,
    output logic side_pend,
    output logic ped_pend
);

    localparam longint T_MAX = 64'd1 << CNT_W;
    localparam bit PARAMS_OK =
        (T_MIN_GRN >= 1) && (T_MIN_GRN <= T_MAX) &&
        (T_YLW     >= 1) && (T_YLW     <= T_MAX) &&
        (T_AR      >= 1) && (T_AR      <= T_MAX) &&
        (T_SIDE    >= 1) && (T_SIDE    <= T_MAX) &&
        (T_WALK    >= 1) && (T_WALK    <= T_MAX) &&
        (T_FLASH   >= 1) && (T_FLASH   <= T_MAX);

    generate
        if (!PARAMS_OK) begin : g_param_check
            $error("fsm_intersection_ctrl: phase durations must lie in 1..2**CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LD_MIN_GRN = CNT_W'(T_MIN_GRN - 1);
    localparam logic [CNT_W-1:0] LD_YLW     = CNT_W'(T_YLW - 1);
    localparam logic [CNT_W-1:0] LD_AR      = CNT_W'(T_AR - 1);
    localparam logic [CNT_W-1:0] LD_SIDE    = CNT_W'(T_SIDE - 1);
    localparam logic [CNT_W-1:0] LD_WALK    = CNT_W'(T_WALK - 1);
`ifdef FSM_NIGHT_FLASH_EN
    localparam logic [CNT_W-1:0] LD_FLASH   = CNT_W'(T_FLASH - 1);
`endif

    typedef enum logic [2:0] {
        ST_MAIN_GRN = 3'd0,
        ST_MAIN_YLW = 3'd1,
        ST_ALL_RED1 = 3'd2,
        ST_SIDE_GRN = 3'd3,
        ST_SIDE_YLW = 3'd4,
        ST_PED_WALK = 3'd5,
`ifdef FSM_NIGHT_FLASH_EN
        ST_ALL_RED2 = 3'd6,
        ST_FLASH    = 3'd7
`else
        ST_ALL_RED2 = 3'd6
`endif
    } state_t;

    typedef enum logic [1:0] {
        GNT_SIDE  = 2'd0,
        GNT_PED   = 2'd1,
        GNT_NIGHT = 2'd2
    } grant_t;

    state_t           state_q, state_d;
    grant_t           grant_q, grant_d;
    logic             last_side_q, last_side_d;
    logic             side_pend_q, side_pend_d;
    logic             ped_pend_q, ped_pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] load_val;
    logic             tmr_done;
    logic             side_eff;
    logic             ped_eff;
`ifdef FSM_NIGHT_FLASH_EN
    logic             flash_on_q, flash_on_d;
`endif

    assign tmr_done = (cnt_q == '0);
    // Requests arriving in the exit cycle still take part in the grant decision.
    assign side_eff = side_pend_q | side_car;
    assign ped_eff  = ped_pend_q | ped_btn;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        unique case (state_q)
            ST_MAIN_GRN: begin
`ifdef FSM_NIGHT_FLASH_EN
                if (night) begin
                    state_d = ST_MAIN_YLW;
                    grant_d = GNT_NIGHT;
                end else
`endif
                if (tmr_done && (side_pend_q || ped_pend_q)) begin
                    state_d = ST_MAIN_YLW;
                    if (side_eff && ped_eff) begin
                        grant_d = last_side_q ? GNT_PED : GNT_SIDE;
                    end else begin
                        grant_d = side_eff ? GNT_SIDE : GNT_PED;
                    end
                end
            end
            ST_MAIN_YLW: if (tmr_done) state_d = ST_ALL_RED1;
            ST_ALL_RED1: begin
                if (tmr_done) begin
                    if (grant_q == GNT_SIDE) begin
                        state_d = ST_SIDE_GRN;
`ifdef FSM_NIGHT_FLASH_EN
                    end else if (grant_q == GNT_NIGHT) begin
                        state_d = ST_FLASH;
`endif
                    end else begin
                        state_d = ST_PED_WALK;
                    end
                end
            end
            ST_SIDE_GRN: if (tmr_done) state_d = ST_SIDE_YLW;
            ST_SIDE_YLW: if (tmr_done) state_d = ST_ALL_RED2;
            ST_PED_WALK: if (tmr_done) state_d = ST_ALL_RED2;
            ST_ALL_RED2: if (tmr_done) state_d = ST_MAIN_GRN;
`ifdef FSM_NIGHT_FLASH_EN
            ST_FLASH:    if (!night) state_d = ST_ALL_RED2;
`endif
            default:     state_d = ST_ALL_RED2;
        endcase
    end

    always_comb begin
        last_side_d = last_side_q;
        side_pend_d = side_pend_q | (side_car && (state_q != ST_SIDE_GRN) && (state_q != ST_SIDE_YLW));
        ped_pend_d  = ped_pend_q | (ped_btn && (state_q != ST_PED_WALK));
        // Clearing on service entry wins over a request in the same cycle.
        if (state_d == ST_SIDE_GRN && state_q != ST_SIDE_GRN) begin
            side_pend_d = 1'b0;
            last_side_d = 1'b1;
        end
        if (state_d == ST_PED_WALK && state_q != ST_PED_WALK) begin
            ped_pend_d  = 1'b0;
            last_side_d = 1'b0;
        end
`ifdef FSM_NIGHT_FLASH_EN
        if (state_q == ST_FLASH || state_d == ST_FLASH) begin
            side_pend_d = 1'b0;
            ped_pend_d  = 1'b0;
        end
`endif
    end

    always_comb begin
        load_val = LD_AR;
        case (state_d)
            ST_MAIN_GRN: load_val = LD_MIN_GRN;
            ST_MAIN_YLW: load_val = LD_YLW;
            ST_SIDE_GRN: load_val = LD_SIDE;
            ST_SIDE_YLW: load_val = LD_YLW;
            ST_PED_WALK: load_val = LD_WALK;
`ifdef FSM_NIGHT_FLASH_EN
            ST_FLASH:    load_val = LD_FLASH;
`endif
            default:     load_val = LD_AR;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
`ifdef FSM_NIGHT_FLASH_EN
        flash_on_d = flash_on_q;
`endif
        if (state_d != state_q) begin
            cnt_d = load_val;
`ifdef FSM_NIGHT_FLASH_EN
            flash_on_d = 1'b1;
        end else if (state_q == ST_FLASH && tmr_done) begin
            cnt_d      = LD_FLASH;
            flash_on_d = ~flash_on_q;
`endif
        end else if (!tmr_done) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_MAIN_GRN;
            grant_q     <= GNT_SIDE;
            last_side_q <= 1'b0;
            side_pend_q <= 1'b0;
            ped_pend_q  <= 1'b0;
            cnt_q       <= LD_MIN_GRN;
`ifdef FSM_NIGHT_FLASH_EN
            flash_on_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_side_q <= last_side_d;
            side_pend_q <= side_pend_d;
            ped_pend_q  <= ped_pend_d;
            cnt_q       <= cnt_d;
`ifdef FSM_NIGHT_FLASH_EN
            flash_on_q  <= flash_on_d;
`endif
        end
    end

    // Lamps decode the state register only; unknown encodings show all-red.
    always_comb begin
        main_grn = 1'b0;
        main_ylw = 1'b0;
        main_red = 1'b0;
        side_grn = 1'b0;
        side_ylw = 1'b0;
        side_red = 1'b0;
        walk     = 1'b0;
        case (state_q)
            ST_MAIN_GRN: begin main_grn = 1'b1; side_red = 1'b1; end
            ST_MAIN_YLW: begin main_ylw = 1'b1; side_red = 1'b1; end
            ST_SIDE_GRN: begin main_red = 1'b1; side_grn = 1'b1; end
            ST_SIDE_YLW: begin main_red = 1'b1; side_ylw = 1'b1; end
            ST_PED_WALK: begin main_red = 1'b1; side_red = 1'b1; walk = 1'b1; end
`ifdef FSM_NIGHT_FLASH_EN
            ST_FLASH:    begin main_ylw = flash_on_q; side_red = flash_on_q; end
`endif
            default:     begin main_red = 1'b1; side_red = 1'b1; end
        endcase
    end

    assign side_pend = side_pend_q;
    assign ped_pend  = ped_pend_q;

endmodule

// File: tb/tb_fsm_intersection_ctrl.sv
// Randomized scoreboard bench for fsm_intersection_ctrl (default build, no night mode).
// A phase/age reference model predicts lamps and pending flags for every cycle.
module tb_fsm_intersection_ctrl;

    localparam int TMG = 8;
    localparam int TY  = 3;
    localparam int TAR = 2;
    localparam int TS  = 6;
    localparam int TW  = 5;

    logic clk = 1'b0;
    logic rst, side_car, ped_btn;
    logic main_grn, main_ylw, main_red, side_grn, side_ylw, side_red, walk;
    logic side_pend, ped_pend;

    always #5 clk = ~clk;

    fsm_intersection_ctrl #(
        .CNT_W(16), .T_MIN_GRN(TMG), .T_YLW(TY), .T_AR(TAR),
        .T_SIDE(TS), .T_WALK(TW), .T_FLASH(4)
    ) dut (
        .clk(clk), .rst(rst), .side_car(side_car), .ped_btn(ped_btn),
        .main_grn(main_grn), .main_ylw(main_ylw), .main_red(main_red),
        .side_grn(side_grn), .side_ylw(side_ylw), .side_red(side_red),
        .walk(walk), .side_pend(side_pend), .ped_pend(ped_pend)
    );

    typedef struct packed {
        logic [6:0] lamps;
        logic       sp;
        logic       pp;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: current phase plus cycles already spent in it.
    typedef enum int {P_MG, P_MY, P_AR1, P_SG, P_SY, P_PW, P_AR2} phase_e;
    phase_e m_phase = P_MG;
    int     m_age = 0;
    bit     m_sp = 0, m_pp = 0, m_last_side = 0, m_grant_side = 0, m_valid = 0;

    function automatic int dur(phase_e p);
        case (p)
            P_MG:         return TMG;
            P_MY, P_SY:   return TY;
            P_SG:         return TS;
            P_PW:         return TW;
            default:      return TAR;
        endcase
    endfunction

    // {main_grn, main_ylw, main_red, side_grn, side_ylw, side_red, walk}
    function automatic logic [6:0] lamps_of(phase_e p);
        case (p)
            P_MG:    return 7'b100_001_0;
            P_MY:    return 7'b010_001_0;
            P_SG:    return 7'b001_100_0;
            P_SY:    return 7'b001_010_0;
            P_PW:    return 7'b001_001_1;
            default: return 7'b001_001_0;
        endcase
    endfunction

    task automatic model_step(bit r, bit s, bit p);
        phase_e nxt;
        bit     done, sp_n, pp_n, ws, wp;
        if (r) begin
            m_phase = P_MG; m_age = 0; m_sp = 0; m_pp = 0; m_last_side = 0;
            return;
        end
        done = (m_age >= dur(m_phase) - 1);
        sp_n = m_sp | (s && m_phase != P_SG && m_phase != P_SY);
        pp_n = m_pp | (p && m_phase != P_PW);
        ws   = m_sp | s;
        wp   = m_pp | p;
        nxt  = m_phase;
        case (m_phase)
            P_MG:  if (done && (m_sp || m_pp)) begin
                       nxt = P_MY;
                       m_grant_side = (ws && wp) ? !m_last_side : ws;
                   end
            P_MY:  if (done) nxt = P_AR1;
            P_AR1: if (done) nxt = m_grant_side ? P_SG : P_PW;
            P_SG:  if (done) nxt = P_SY;
            P_SY:  if (done) nxt = P_AR2;
            P_PW:  if (done) nxt = P_AR2;
            P_AR2: if (done) nxt = P_MG;
            default: nxt = P_AR2;
        endcase
        if (nxt == P_SG && m_phase != P_SG) begin sp_n = 0; m_last_side = 1; end
        if (nxt == P_PW && m_phase != P_PW) begin pp_n = 0; m_last_side = 0; end
        m_age   = (nxt != m_phase) ? 0 : m_age + 1;
        m_phase = nxt;
        m_sp    = sp_n;
        m_pp    = pp_n;
    endtask

    // One clock cycle: publish the expectation for the current state, drive inputs, advance.
    task automatic cycle(bit r, bit s, bit p);
        if (m_valid) exp_q.push_back({lamps_of(m_phase), m_sp, m_pp});
        rst      = r;
        side_car = s;
        ped_btn  = p;
        model_step(r, s, p);
        if (r) m_valid = 1;
        @(posedge clk);
        #1;
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if ({main_grn, main_ylw, main_red, side_grn, side_ylw, side_red, walk} != mon_e.lamps) begin
                failures++;
                $display("FAIL lamps t=%0t got=%b exp=%b", $time,
                         {main_grn, main_ylw, main_red, side_grn, side_ylw, side_red, walk}, mon_e.lamps);
            end
            checks++;
            if ({side_pend, ped_pend} != {mon_e.sp, mon_e.pp}) begin
                failures++;
                $display("FAIL pend t=%0t got side=%b ped=%b exp side=%b ped=%b", $time,
                         side_pend, ped_pend, mon_e.sp, mon_e.pp);
            end
            checks++;
            if (!$onehot({main_grn, main_ylw, main_red}) || !$onehot({side_grn, side_ylw, side_red})) begin
                failures++;
                $display("FAIL onehot t=%0t got main=%b side=%b exp one lamp per road", $time,
                         {main_grn, main_ylw, main_red}, {side_grn, side_ylw, side_red});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int hold_s, hold_p;
        bit rs, rp, rr;
        rst = 1'b1; side_car = 1'b0; ped_btn = 1'b0;
        hold_s = 0; hold_p = 0;

        cycle(1, 0, 0);
        cycle(1, 0, 0);
        repeat (50) cycle(0, 0, 0);

        // Single side pulse at cycle 2.
        cycle(1, 0, 0);
        for (int i = 0; i < 30; i++) cycle(0, i == 2, 0);

        // Both requests at cycle 1: side first, pedestrian on the next round.
        cycle(1, 0, 0);
        for (int i = 0; i < 50; i++) cycle(0, i == 1, i == 1);

        // Side sensor held only while side road is served.
        cycle(1, 0, 0);
        for (int i = 0; i < 60; i++) cycle(0, (i == 0) || m_phase == P_SG || m_phase == P_SY, 0);

        // Reset in the middle of side green, then a fresh request.
        cycle(1, 0, 0);
        for (int i = 0; i < 15; i++) cycle(0, i == 2, 0);
        cycle(1, 0, 0);
        for (int i = 0; i < 30; i++) cycle(0, i == 0, 0);

        // Randomized traffic with pulses, held levels and rare resets.
        for (int i = 0; i < 3000; i++) begin
            if (hold_s > 0) hold_s--; else if ($urandom_range(0, 39) == 0) hold_s = $urandom_range(1, 12);
            if (hold_p > 0) hold_p--; else if ($urandom_range(0, 49) == 0) hold_p = $urandom_range(1, 8);
            rs = (hold_s > 0) || ($urandom_range(0, 29) == 0);
            rp = (hold_p > 0) || ($urandom_range(0, 29) == 0);
            rr = ($urandom_range(0, 699) == 0);
            cycle(rr, rs, rp);
        end

        rst = 1'b0; side_car = 1'b0; ped_btn = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsm_intersection_ctrl.md
Name: fsm_intersection_ctrl

Overview:
- Two-road intersection controller: main road and side road, each with a 3-lamp signal head, plus a pedestrian crossing (walk lamp).
- Main road rests green. Side-road car sensor and pedestrian button are requesters; the block latches requests and arbitrates the intersection between them.
- Sequences yellow and all-red clearance phases, then returns to main green.
- Sits above the per-lamp drivers; its outputs drive the lamps directly.

Parameters:
- CNT_W, 16, phase counter width in bits.
- T_MIN_GRN, 1500, minimum main-green duration in clk cycles.
- T_YLW, 1500, yellow duration for either road, in cycles.
- T_AR, 500, all-red clearance duration, in cycles.
- T_SIDE, 7500, side-road green duration, in cycles.
- T_WALK, 5000, pedestrian walk duration, in cycles.
- T_FLASH, 500, flash half-period in cycles (used only with the optional feature).
- Legality: every T_* must be >=1 and <=2^CNT_W.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- side_car  input  1  side-road car sensor, level or single-cycle pulse.
- ped_btn  input  1  pedestrian button, level or single-cycle pulse.
- main_grn / main_ylw / main_red  output  1 each  main-road lamps.
- side_grn / side_ylw / side_red  output  1 each  side-road lamps.
- walk  output  1  pedestrian walk lamp.
- side_pend  output  1  side request latched and not yet served.
- ped_pend  output  1  pedestrian request latched and not yet served.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst=1 at a clk edge, including mid-phase) forces:
  - state MAIN_GRN, counter = T_MIN_GRN-1, side_pend=0, ped_pend=0, last_srv=PED.
  - Outputs main_grn=1, side_red=1, all other lamps 0, walk=0.
- Lamp outputs are a Moore decode of the state register: valid in the same cycle as the state. Exactly one lamp per road is lit in every state.
- Phase timer:
  - On entry to a state, counter loads T_state-1.
  - It decrements by 1 each cycle and never wraps below 0.
  - A timed state with duration T therefore occupies exactly T cycles.
- Request latching:
  - side_pend sets when side_car=1 in any state except SIDE_GRN/SIDE_YLW.
  - ped_pend sets when ped_btn=1 in any state except PED_WALK.
  - Set takes effect the next cycle; the flag is sticky.
  - A flag clears on the edge entering its service state (SIDE_GRN / PED_WALK). A request asserted in that same cycle is discarded.
- State machine:
  - MAIN_GRN (T_MIN_GRN, then holds at counter=0) -> MAIN_YLW when counter==0 and (side_pend or ped_pend).
  - At that exit edge, register grant:
    - only one request pending -> grant to it;
    - both pending -> grant to the requester != last_srv.
  - A request set in the exit cycle itself is counted.
  - MAIN_YLW (T_YLW) -> ALL_RED1.
  - ALL_RED1 (T_AR) -> SIDE_GRN if grant=SIDE, else PED_WALK.
  - SIDE_GRN (T_SIDE) -> SIDE_YLW (T_YLW) -> ALL_RED2. last_srv<=SIDE on entry to SIDE_GRN.
  - PED_WALK (T_WALK) -> ALL_RED2. last_srv<=PED on entry.
  - ALL_RED2 (T_AR) -> MAIN_GRN (counter reloads T_MIN_GRN-1).
  - Illegal/unused encoding -> ALL_RED2 next cycle.
- Lamps per state:
  - MAIN_GRN: main_grn, side_red.
  - MAIN_YLW: main_ylw, side_red.
  - ALL_RED1/2: main_red, side_red.
  - SIDE_GRN: main_red, side_grn.
  - SIDE_YLW: main_red, side_ylw.
  - PED_WALK: main_red, side_red, walk.
- A request still pending at MAIN_GRN re-entry is served after a fresh T_MIN_GRN. Main green is never shortened.

Optional Feature:
- Macro FSM_NIGHT_FLASH_EN.
- Defined:
  - Adds input port night (1 bit) and state FLASH.
  - In MAIN_GRN with night=1 (priority over pending requests) -> MAIN_YLW -> ALL_RED1 -> FLASH.
  - In FLASH: main_ylw and side_red blink together, toggling every T_FLASH cycles, starting on. All other lamps are 0.
  - Both pend flags are cleared and not latched while in FLASH.
  - night=0 in FLASH -> ALL_RED2 -> MAIN_GRN.
- Undefined: no night port, no FLASH state, behaviour exactly as above.

Test Plan (T_MIN_GRN=8, T_YLW=3, T_AR=2, T_SIDE=6, T_WALK=5; cycle 0 = first cycle after rst deassert):
- Idle: no requests for 50 cycles -> main_grn=1, side_red=1 throughout; side_pend=ped_pend=0.
- side_car pulse at cycle 2 -> side_pend=1 from cycle 3; MAIN_GRN 0-7, MAIN_YLW 8-10, ALL_RED1 11-12, SIDE_GRN 13-18 (side_pend=0 at 13), SIDE_YLW 19-21, ALL_RED2 22-23, MAIN_GRN at 24.
- side_car and ped_btn both pulsed at cycle 1 -> side served first (SIDE_GRN at 13). ped_pend stays 1. Next MAIN_GRN 24-31, MAIN_YLW 32-34, ALL_RED1 35-36, PED_WALK 37-41 with walk=1.
- side_car held high during SIDE_GRN/SIDE_YLW only -> side_pend stays 0; MAIN_GRN holds indefinitely after return.
- rst=1 at cycle 15 (mid SIDE_GRN) -> cycle 16: MAIN_GRN lamps, pend flags 0. A new request is served after 8 fresh green cycles.
- FSM_NIGHT_FLASH_EN, night=1 at cycle 3 -> MAIN_YLW 4-6, ALL_RED1 7-8, FLASH from 9 with main_ylw toggling every T_FLASH. night=0 -> ALL_RED2 (2 cycles) -> MAIN_GRN.
